// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared encodings for the multi-cycle RV32I control unit
// Holds the FSM state encoding, RV32I opcodes, ALU operation codes,
// the instruction-class enum and the opcode/funct3 class decoder.
package ctrl_pkg;

    typedef enum logic [2:0] {
        S_IF  = 3'd0,
        S_ID  = 3'd1,
        S_EX  = 3'd2,
        S_MEM = 3'd3,
        S_WB  = 3'd4
    } state_t;

    typedef enum logic [2:0] {
        C_NOP,
        C_R,
        C_I,
        C_LW,
        C_SW,
        C_BEQ
    } iclass_t;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_SRL = 4'b1000;
    localparam logic [3:0] ALU_SLL = 4'b1001;
    localparam logic [3:0] ALU_SRA = 4'b1010;
    localparam logic [3:0] ALU_XOR = 4'b1101;

    // Loads, stores and branches are only recognised with their single
    // supported funct3; any other encoding falls through to NOP.
    function automatic iclass_t decode_class(input logic [6:0] op, input logic [2:0] f3);
        return op == OP_R                    ? C_R   :
               op == OP_I                    ? C_I   :
               (op == OP_LW  && f3 == 3'b010) ? C_LW  :
               (op == OP_SW  && f3 == 3'b010) ? C_SW  :
               (op == OP_BEQ && f3 == 3'b000) ? C_BEQ : C_NOP;
    endfunction

endpackage

// File: rtl/alu_decoder.sv
// alu_decoder: maps instruction class, funct3 and funct7[5] to ALUCtrl
// Ports:
//   cls_i      instruction class
//   funct3_i   instr[14:12]
//   funct7b5_i instr[30]
//   alu_ctrl_o ALU operation code
module alu_decoder
    import ctrl_pkg::*;
(
    input  iclass_t    cls_i,
    input  logic [2:0] funct3_i,
    input  logic       funct7b5_i,
    output logic [3:0] alu_ctrl_o
);

    always_comb begin
        alu_ctrl_o = ALU_ADD;
        if (cls_i == C_BEQ)
            alu_ctrl_o = ALU_SUB;
        else if (cls_i == C_R || cls_i == C_I)
            case (funct3_i)
                // funct7[5] selects SUB only for register-register ops; ADDI
                // carries immediate bits there.
                3'b000:  alu_ctrl_o = (cls_i == C_R && funct7b5_i) ? ALU_SUB : ALU_ADD;
                3'b001:  alu_ctrl_o = ALU_SLL;
                3'b010:  alu_ctrl_o = ALU_SLT;
                3'b100:  alu_ctrl_o = ALU_XOR;
                3'b101:  alu_ctrl_o = funct7b5_i ? ALU_SRA : ALU_SRL;
                3'b110:  alu_ctrl_o = ALU_OR;
                3'b111:  alu_ctrl_o = ALU_AND;
                default: alu_ctrl_o = ALU_ADD;
            endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: IF/ID/EX/MEM/WB sequencer and decoder for an RV32I datapath
// Ports:
//   clk, rst          clock, asynchronous active-low reset
//   en                run enable, sampled in IF
//   instr             instruction word, stable from ID through WB
//   Zero              ALU zero flag
//   dmem_ready        data-memory access complete
//   PCSrc, loadPC     PC source select and PC load strobe
//   ALUSrc, ALUCtrl   ALU operand-2 select and operation
//   RegWrite, MemToReg register write strobe and write-back source
//   MemRead, MemWrite data-memory strobes
//   illegal           pulse in WB for an unsupported instruction
//   state             FSM state for debug
//   retired           completed-instruction count
module multicycle_ctrl
    import ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [31:0]      instr,
    input  logic             Zero,
    input  logic             dmem_ready,
    output logic             PCSrc,
    output logic             ALUSrc,
    output logic             RegWrite,
    output logic             MemToReg,
    output logic             loadPC,
    output logic [3:0]       ALUCtrl,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             illegal,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] retired
);

    state_t           state_q, state_d;
    iclass_t          cls_q, cls_d;
    logic             alu_src_q, alu_src_d;
    logic             mem_to_reg_q, mem_to_reg_d;
    logic [3:0]       alu_ctrl_q, alu_ctrl_d;
    logic [CNT_W-1:0] retired_q, retired_d;
    logic             unused_instr_bits;

    // Register numbers and immediate bits are the datapath's business.
    assign unused_instr_bits = ^{instr[31], instr[29:15], instr[11:7]};

    assign cls_d        = decode_class(instr[6:0], instr[14:12]);
    assign alu_src_d    = cls_d inside {C_I, C_LW, C_SW};
    assign mem_to_reg_d = cls_d == C_LW;
    assign retired_d    = retired_q + CNT_W'(state_q == S_WB);

    alu_decoder u_alu_decoder (
        .cls_i      (cls_d),
        .funct3_i   (instr[14:12]),
        .funct7b5_i (instr[30]),
        .alu_ctrl_o (alu_ctrl_d)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state_q <= S_IF;
        else
            state_q <= state_d;
    end

    // Decode is captured once on the ID exit and held until the next one.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cls_q        <= C_NOP;
            alu_src_q    <= 1'b0;
            mem_to_reg_q <= 1'b0;
            alu_ctrl_q   <= ALU_ADD;
            retired_q    <= '0;
        end else begin
            if (state_q == S_ID) begin
                cls_q        <= cls_d;
                alu_src_q    <= alu_src_d;
                mem_to_reg_q <= mem_to_reg_d;
                alu_ctrl_q   <= alu_ctrl_d;
            end
            retired_q <= retired_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IF:    state_d = en ? S_ID : S_IF;
            S_ID:    state_d = S_EX;
            S_EX:    state_d = S_MEM;
            S_MEM:   state_d = ((cls_q == C_LW || cls_q == C_SW) && !dmem_ready) ? S_MEM : S_WB;
            S_WB:    state_d = S_IF;
            default: state_d = S_IF;
        endcase
    end

    always_comb begin
        MemRead  = state_q == S_MEM && cls_q == C_LW;
        MemWrite = state_q == S_MEM && cls_q == C_SW;
        RegWrite = state_q == S_WB && cls_q inside {C_R, C_I, C_LW};
        loadPC   = state_q == S_WB;
        PCSrc    = state_q == S_WB && cls_q == C_BEQ && Zero;
        illegal  = state_q == S_WB && cls_q == C_NOP;
    end

    assign ALUSrc   = alu_src_q;
    assign MemToReg = mem_to_reg_q;
    assign ALUCtrl  = alu_ctrl_q;
    assign state    = state_q;
    assign retired  = retired_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: directed self-checking bench for multicycle_ctrl
module tb_multicycle_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        en = 1'b0;
    logic [31:0] instr = 32'h0;
    logic        Zero = 1'b0;
    logic        dmem_ready = 1'b1;
    logic        PCSrc, ALUSrc, RegWrite, MemToReg, loadPC, MemRead, MemWrite, illegal;
    logic [3:0]  ALUCtrl;
    logic [2:0]  state;
    logic [31:0] retired;
    logic [5:0]  strb;
    int          errors = 0;
    int          checks = 0;
    int          exp_ret = 0;

    multicycle_ctrl #(.CNT_W(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .instr      (instr),
        .Zero       (Zero),
        .dmem_ready (dmem_ready),
        .PCSrc      (PCSrc),
        .ALUSrc     (ALUSrc),
        .RegWrite   (RegWrite),
        .MemToReg   (MemToReg),
        .loadPC     (loadPC),
        .ALUCtrl    (ALUCtrl),
        .MemRead    (MemRead),
        .MemWrite   (MemWrite),
        .illegal    (illegal),
        .state      (state),
        .retired    (retired)
    );

    always #5 clk = ~clk;

    // {PCSrc, RegWrite, loadPC, MemRead, MemWrite, illegal}
    assign strb = {PCSrc, RegWrite, loadPC, MemRead, MemWrite, illegal};

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic test_reset();
        rst = 1'b0; en = 1'b1; instr = 32'h00500093;
        repeat (3) @(negedge clk);
        checks++; if (state !== 3'd0) begin errors++; $display("FAIL reset_state got %0d exp 0", state); end
        checks++; if (strb !== 6'b0) begin errors++; $display("FAIL reset_strobes got %b exp 000000", strb); end
        checks++; if (retired !== 32'd0) begin errors++; $display("FAIL reset_retired got %0d exp 0", retired); end
        checks++; if ({ALUSrc, MemToReg, ALUCtrl} !== 6'b00_0010) begin errors++; $display("FAIL reset_decode got %b exp 000010", {ALUSrc, MemToReg, ALUCtrl}); end
        en = 1'b0; rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++; if ({state, strb} !== 9'b0 || retired !== 32'd0) begin errors++; $display("FAIL en_low_idle got state=%0d strb=%b ret=%0d exp 0/000000/0", state, strb, retired); end
        end
    endtask

    task automatic test_addi();
        instr = 32'h00500093; en = 1'b1; Zero = 1'b0; dmem_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            if (c == 1) en = 1'b0;
            checks++; if (state !== 3'(c)) begin errors++; $display("FAIL addi_state c=%0d got %0d exp %0d", c, state, c); end
            checks++; if (strb !== (c == 4 ? 6'b011000 : 6'b0)) begin errors++; $display("FAIL addi_strobes c=%0d got %b", c, strb); end
            if (c >= 2) begin
                checks++; if ({ALUSrc, MemToReg, ALUCtrl} !== 6'b10_0010) begin errors++; $display("FAIL addi_decode c=%0d got %b exp 100010", c, {ALUSrc, MemToReg, ALUCtrl}); end
            end
            @(negedge clk);
        end
        exp_ret++;
        checks++; if (state !== 3'd0 || retired !== 32'(exp_ret)) begin errors++; $display("FAIL addi_retire got state=%0d ret=%0d exp 0/%0d", state, retired, exp_ret); end
        @(negedge clk);
        checks++; if (state !== 3'd0) begin errors++; $display("FAIL addi_idle got %0d exp 0", state); end
    endtask

    task automatic test_sub();
        instr = 32'h402081B3; en = 1'b1; Zero = 1'b1; dmem_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            if (c == 1) en = 1'b0;
            checks++; if (state !== 3'(c)) begin errors++; $display("FAIL sub_state c=%0d got %0d exp %0d", c, state, c); end
            checks++; if (strb !== (c == 4 ? 6'b011000 : 6'b0)) begin errors++; $display("FAIL sub_strobes c=%0d got %b", c, strb); end
            if (c >= 2) begin
                checks++; if ({ALUSrc, MemToReg, ALUCtrl} !== 6'b00_0110) begin errors++; $display("FAIL sub_decode c=%0d got %b exp 000110", c, {ALUSrc, MemToReg, ALUCtrl}); end
            end
            @(negedge clk);
        end
        Zero = 1'b0; exp_ret++;
        checks++; if (retired !== 32'(exp_ret)) begin errors++; $display("FAIL sub_retire got %0d exp %0d", retired, exp_ret); end
    endtask

    task automatic test_sw_wait();
        int es;
        instr = 32'h0020A423; en = 1'b1;
        for (int c = 0; c < 8; c++) begin
            if (c == 1) en = 1'b0;
            dmem_ready = (c < 3 || c >= 6);
            es = c < 3 ? c : (c < 7 ? 3 : 4);
            checks++; if (state !== 3'(es)) begin errors++; $display("FAIL sw_state c=%0d got %0d exp %0d", c, state, es); end
            checks++; if (strb !== (es == 3 ? 6'b000010 : es == 4 ? 6'b001000 : 6'b0)) begin errors++; $display("FAIL sw_strobes c=%0d got %b", c, strb); end
            if (c >= 2) begin
                checks++; if ({ALUSrc, MemToReg, ALUCtrl} !== 6'b10_0010) begin errors++; $display("FAIL sw_decode c=%0d got %b exp 100010", c, {ALUSrc, MemToReg, ALUCtrl}); end
            end
            @(negedge clk);
        end
        exp_ret++;
        checks++; if (state !== 3'd0 || retired !== 32'(exp_ret)) begin errors++; $display("FAIL sw_retire got state=%0d ret=%0d exp 0/%0d", state, retired, exp_ret); end
    endtask

    task automatic test_lw();
        instr = 32'h0080A203; en = 1'b1; dmem_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            if (c == 1) en = 1'b0;
            checks++; if (state !== 3'(c)) begin errors++; $display("FAIL lw_state c=%0d got %0d exp %0d", c, state, c); end
            checks++; if (strb !== (c == 3 ? 6'b000100 : c == 4 ? 6'b011000 : 6'b0)) begin errors++; $display("FAIL lw_strobes c=%0d got %b", c, strb); end
            if (c >= 2) begin
                checks++; if ({ALUSrc, MemToReg, ALUCtrl} !== 6'b11_0010) begin errors++; $display("FAIL lw_decode c=%0d got %b exp 110010", c, {ALUSrc, MemToReg, ALUCtrl}); end
            end
            @(negedge clk);
        end
        exp_ret++;
        checks++; if (retired !== 32'(exp_ret)) begin errors++; $display("FAIL lw_retire got %0d exp %0d", retired, exp_ret); end
    endtask

    task automatic test_beq(input logic z);
        instr = 32'h00208463; en = 1'b1; dmem_ready = 1'b0; Zero = z;
        for (int c = 0; c < 5; c++) begin
            if (c == 1) en = 1'b0;
            checks++; if (state !== 3'(c)) begin errors++; $display("FAIL beq_state z=%0d c=%0d got %0d exp %0d", z, c, state, c); end
            checks++; if (strb !== (c == 4 ? {z, 5'b01000} : 6'b0)) begin errors++; $display("FAIL beq_strobes z=%0d c=%0d got %b", z, c, strb); end
            if (c >= 2) begin
                checks++; if ({ALUSrc, MemToReg, ALUCtrl} !== 6'b00_0110) begin errors++; $display("FAIL beq_decode c=%0d got %b exp 000110", c, {ALUSrc, MemToReg, ALUCtrl}); end
            end
            @(negedge clk);
        end
        Zero = 1'b0; dmem_ready = 1'b1; exp_ret++;
        checks++; if (retired !== 32'(exp_ret)) begin errors++; $display("FAIL beq_retire got %0d exp %0d", retired, exp_ret); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] tab_i [12] = '{32'h40315093, 32'h40000093, 32'h0010E093, 32'h0010A093,
                                    32'h0020C1B3, 32'h4020D1B3, 32'h0020D1B3, 32'h0020A1B3,
                                    32'h002091B3, 32'h0020F1B3, 32'h0020B1B3, 32'h00008203};
        logic [4:0]  tab_d [12] = '{5'b1_1010, 5'b1_0010, 5'b1_0001, 5'b1_0111,
                                    5'b0_1101, 5'b0_1010, 5'b0_1000, 5'b0_0111,
                                    5'b0_1001, 5'b0_0000, 5'b0_0010, 5'b0_0010};
        logic [5:0]  tab_w [12] = '{6'b011000, 6'b011000, 6'b011000, 6'b011000,
                                    6'b011000, 6'b011000, 6'b011000, 6'b011000,
                                    6'b011000, 6'b011000, 6'b011000, 6'b001001};
        en = 1'b1; dmem_ready = 1'b1;
        for (int e = 0; e < 12; e++) begin
            instr = tab_i[e];
            for (int c = 0; c < 5; c++) begin
                checks++; if (state !== 3'(c)) begin errors++; $display("FAIL b2b_state e=%0d c=%0d got %0d exp %0d", e, c, state, c); end
                if (c == 2) begin
                    checks++; if ({ALUSrc, ALUCtrl} !== tab_d[e]) begin errors++; $display("FAIL b2b_decode e=%0d got %b exp %b", e, {ALUSrc, ALUCtrl}, tab_d[e]); end
                end
                if (c == 3) begin
                    checks++; if (strb !== 6'b0) begin errors++; $display("FAIL b2b_mem e=%0d got %b exp 000000", e, strb); end
                end
                if (c == 4) begin
                    checks++; if (strb !== tab_w[e]) begin errors++; $display("FAIL b2b_wb e=%0d got %b exp %b", e, strb, tab_w[e]); end
                end
                @(negedge clk);
            end
            exp_ret++;
        end
        en = 1'b0;
        checks++; if (retired !== 32'(exp_ret)) begin errors++; $display("FAIL b2b_retire got %0d exp %0d", retired, exp_ret); end
    endtask

    task automatic test_reset_mid_mem();
        instr = 32'h0020A423; en = 1'b1; dmem_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            if (c == 1) en = 1'b0;
            @(negedge clk);
        end
        checks++; if (state !== 3'd3 || MemWrite !== 1'b1) begin errors++; $display("FAIL rst_pre got state=%0d MemWrite=%b exp 3/1", state, MemWrite); end
        #1 rst = 1'b0;
        #1;
        exp_ret = 0;
        checks++; if (MemWrite !== 1'b0 || state !== 3'd0 || retired !== 32'd0) begin errors++; $display("FAIL rst_async got MemWrite=%b state=%0d ret=%0d exp 0/0/0", MemWrite, state, retired); end
        checks++; if ({ALUSrc, MemToReg, ALUCtrl} !== 6'b00_0010) begin errors++; $display("FAIL rst_decode got %b exp 000010", {ALUSrc, MemToReg, ALUCtrl}); end
        @(negedge clk);
        rst = 1'b1; dmem_ready = 1'b1;
        instr = 32'hFFFFFFFF; en = 1'b1;
        for (int c = 0; c < 5; c++) begin
            if (c == 1) en = 1'b0;
            checks++; if (state !== 3'(c)) begin errors++; $display("FAIL ill_state c=%0d got %0d exp %0d", c, state, c); end
            checks++; if (strb !== (c == 4 ? 6'b001001 : 6'b0)) begin errors++; $display("FAIL ill_strobes c=%0d got %b", c, strb); end
            if (c >= 2) begin
                checks++; if ({ALUSrc, MemToReg, ALUCtrl} !== 6'b00_0010) begin errors++; $display("FAIL ill_decode c=%0d got %b exp 000010", c, {ALUSrc, MemToReg, ALUCtrl}); end
            end
            @(negedge clk);
        end
        exp_ret++;
        checks++; if (retired !== 32'(exp_ret)) begin errors++; $display("FAIL ill_retire got %0d exp %0d", retired, exp_ret); end
    endtask

    initial begin
        test_reset();
        test_addi();
        test_sub();
        test_sw_wait();
        test_lw();
        test_beq(1'b1);
        test_beq(1'b0);
        test_back_to_back();
        test_reset_mid_mem();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
